sprite_blit: RTL

Parametrised sprite blitter, successor to the fixed-scale sprite renderer. It copies one sprite from a synchronous sprite ROM into the framebuffer write port. The sprite is scaled by nearest-neighbour DDA to an arbitrary destination width and height, can be mirrored on either axis, is clipped at the screen edges, and skips transparent pixels. It sits between the sprite-list sequencer (start/done handshake) and the framebuffer BRAM write port, and honours framebuffer backpressure.

---
 rtl/sprite_blit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_blit.sv
// rtl/sprite_blit.sv - nearest-neighbour scaled sprite copy from sprite ROM to framebuffer write port
// Mirror logic is compiled in only when SPRITE_BLIT_FLIP_EN is defined.
module sprite_blit #(
    parameter int                   CORDW      = 10,
    parameter int                   SPR_WIDTH  = 16,
    parameter int                   SPR_HEIGHT = 16,
    parameter int                   SPR_DATAW  = 4,
    parameter int                   FB_WIDTH   = 800,
    parameter int                   FB_HEIGHT  = 480,
    parameter int                   ADDRW      = 19,
    parameter logic [SPR_DATAW-1:0] TRANS_IDX  = 4'hF
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [CORDW-1:0]                        sx,
    input  logic [CORDW-1:0]                        sy,
    input  logic [CORDW-1:0]                        dst_w,
    input  logic [CORDW-1:0]                        dst_h,
    input  logic                                    flip_x,
    input  logic                                    flip_y,
    output logic                                    busy,
    output logic                                    done,
    output logic [$clog2(SPR_WIDTH*SPR_HEIGHT)-1:0] spr_addr,
    output logic                                    spr_en,
    input  logic [SPR_DATAW-1:0]                    spr_data,
    output logic                                    fb_we,
    input  logic                                    fb_ready,
    output logic [ADDRW-1:0]                        fb_addr,
    output logic [SPR_DATAW-1:0]                    fb_pix
);
    localparam int SAW     = $clog2(SPR_WIDTH*SPR_HEIGHT);
    localparam int SPR_MAX = (SPR_WIDTH > SPR_HEIGHT) ? SPR_WIDTH : SPR_HEIGHT;
    localparam int AW      = CORDW + $clog2(SPR_MAX) + 1;
    localparam int CW1     = CORDW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_next;

    logic [CORDW-1:0] dst_w_r, dst_h_r, col, row;
    logic [CW1-1:0]   sx_r, cur_x, cur_y;
    logic [AW-1:0]    qx, rx, qy, ry, u, v, acc_x, acc_y;
    logic             s0_valid, s1_valid, s2_valid;
    logic [CW1-1:0]   s0_x, s0_y, s1_x, s1_y;

    logic             stall, adv, pipe_empty, load_first, issue;
    logic [CORDW-1:0] nxt_col, nxt_row, dw_div, dh_div;
    logic [CW1-1:0]   nxt_x, nxt_y;
    logic [AW-1:0]    nxt_u, nxt_v, nxt_acc_x, nxt_acc_y, ax_sum, ay_sum;
    logic [AW-1:0]    qx0, rx0, qy0, ry0, sel_u, sel_v, tex_u, tex_v;
    logic             ax_wrap, ay_wrap, last_col, in_range;
    logic [SAW-1:0]   tex_addr;
    logic [ADDRW-1:0] pix_addr;

    assign stall      = fb_we && !fb_ready;
    assign adv        = !stall;
    assign spr_en     = s0_valid && adv;
    assign pipe_empty = !s0_valid && !s1_valid && !s2_valid;
    assign done       = (state == FLUSH) && pipe_empty;
    assign busy       = (state != IDLE) && !done;

    // Per-job DDA steps: whole texels per destination pixel plus a remainder,
    // so a downscale never needs more than one extra subtract per pixel.
    always_comb begin
        dw_div = (dst_w == '0) ? CORDW'(1) : dst_w;
        dh_div = (dst_h == '0) ? CORDW'(1) : dst_h;
        qx0    = AW'(32'(SPR_WIDTH) / 32'(dw_div));
        rx0    = AW'(32'(SPR_WIDTH) % 32'(dw_div));
        qy0    = AW'(32'(SPR_HEIGHT) / 32'(dh_div));
        ry0    = AW'(32'(SPR_HEIGHT) % 32'(dh_div));
    end

    always_comb begin
        last_col  = (col == dst_w_r - CORDW'(1));
        ax_sum    = acc_x + rx;
        ax_wrap   = (ax_sum >= AW'(dst_w_r));
        ay_sum    = acc_y + ry;
        ay_wrap   = (ay_sum >= AW'(dst_h_r));
        nxt_col   = col + CORDW'(1);
        nxt_row   = row;
        nxt_x     = cur_x + CW1'(1);
        nxt_y     = cur_y;
        nxt_u     = u + qx + AW'(ax_wrap);
        nxt_acc_x = ax_wrap ? ax_sum - AW'(dst_w_r) : ax_sum;
        nxt_v     = v;
        nxt_acc_y = acc_y;
        if (last_col) begin
            nxt_col   = '0;
            nxt_row   = row + CORDW'(1);
            nxt_x     = sx_r;
            nxt_y     = cur_y + CW1'(1);
            nxt_u     = '0;
            nxt_acc_x = '0;
            nxt_v     = v + qy + AW'(ay_wrap);
            nxt_acc_y = ay_wrap ? ay_sum - AW'(dst_h_r) : ay_sum;
        end
    end

`ifdef SPRITE_BLIT_FLIP_EN
    logic flip_x_r, flip_y_r, sel_fx, sel_fy;
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_x_r <= 1'b0;
            flip_y_r <= 1'b0;
        end else if (load_first) begin
            flip_x_r <= flip_x;
            flip_y_r <= flip_y;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = flip_x ^ flip_y;
`endif

    always_comb begin
        sel_u = load_first ? '0 : nxt_u;
        sel_v = load_first ? '0 : nxt_v;
`ifdef SPRITE_BLIT_FLIP_EN
        sel_fx = load_first ? flip_x : flip_x_r;
        sel_fy = load_first ? flip_y : flip_y_r;
        tex_u  = sel_fx ? AW'(SPR_WIDTH - 1) - sel_u : sel_u;
        tex_v  = sel_fy ? AW'(SPR_HEIGHT - 1) - sel_v : sel_v;
`else
        tex_u  = sel_u;
        tex_v  = sel_v;
`endif
        tex_addr = SAW'(32'(tex_v) * 32'(SPR_WIDTH) + 32'(tex_u));
    end

    always_comb begin
        in_range = (32'(s1_x) < 32'(FB_WIDTH)) && (32'(s1_y) < 32'(FB_HEIGHT));
        pix_addr = ADDRW'(32'(s1_y) * 32'(FB_WIDTH) + 32'(s1_x));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_first = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (dst_w == '0 || dst_h == '0) begin
                        state_next = FLUSH;
                    end else begin
                        load_first = 1'b1;
                        state_next = (dst_w == CORDW'(1) && dst_h == CORDW'(1)) ? FLUSH : RUN;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    issue = 1'b1;
                    if (nxt_col == dst_w_r - CORDW'(1) && nxt_row == dst_h_r - CORDW'(1))
                        state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (pipe_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_w_r  <= '0;
            dst_h_r  <= '0;
            sx_r     <= '0;
            qx       <= '0;
            rx       <= '0;
            qy       <= '0;
            ry       <= '0;
            col      <= '0;
            row      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            u        <= '0;
            v        <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            s0_valid <= 1'b0;
            spr_addr <= '0;
            s0_x     <= '0;
            s0_y     <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s2_valid <= 1'b0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_pix   <= '0;
        end else begin
            if (load_first) begin
                dst_w_r <= dst_w;
                dst_h_r <= dst_h;
                sx_r    <= {1'b0, sx};
                qx      <= qx0;
                rx      <= rx0;
                qy      <= qy0;
                ry      <= ry0;
                col     <= '0;
                row     <= '0;
                cur_x   <= {1'b0, sx};
                cur_y   <= {1'b0, sy};
                u       <= '0;
                v       <= '0;
                acc_x   <= '0;
                acc_y   <= '0;
            end else if (issue) begin
                col   <= nxt_col;
                row   <= nxt_row;
                cur_x <= nxt_x;
                cur_y <= nxt_y;
                u     <= nxt_u;
                v     <= nxt_v;
                acc_x <= nxt_acc_x;
                acc_y <= nxt_acc_y;
            end
            // Whole pipeline moves together; a stalled write freezes every stage.
            if (adv) begin
                s0_valid <= load_first || issue;
                if (load_first || issue) begin
                    spr_addr <= tex_addr;
                    s0_x     <= load_first ? {1'b0, sx} : nxt_x;
                    s0_y     <= load_first ? {1'b0, sy} : nxt_y;
                end
                s1_valid <= s0_valid;
                s1_x     <= s0_x;
                s1_y     <= s0_y;
                s2_valid <= s1_valid;
                fb_we    <= s1_valid && in_range && (spr_data != TRANS_IDX);
                fb_addr  <= pix_addr;
                fb_pix   <= spr_data;
            end
        end
    end
endmodule
